pd_ana_model: RTL and testbench
===============================

Name: pd_ana_model

Overview:
- Behavioural/synthesizable model of the USB-PD source analog front end (VBUS supply) that sits beside the policy engine inside the PD top level.
- Reports cable attach after reset.
- Accepts transition requests (fixed or PPS PDO, voltage, current) from the policy engine, settles for a fixed time, then pulses trans_finish.
- Publishes PPS status fields (output voltage, output current, PTF, OMF) and a one-cycle alert on status events.

Parameters:
ATTACH_DLY, 16, cycles from reset release to ana2pe_attached assertion (>=1)
SETTLE_DLY, 64, cycles from accepted request to trans_finish pulse (>=1)
PPS_CL_MAX, 60, PPS current-limit ceiling in 50 mA units (3 A); above it OMF=1

Ports:
clk  in  1  single clock
rst  in  1  synchronous reset, active-high
pe2ana_trans_en  in  1  transition request, level-sampled
pe2ana_trans_pdotype  in  1  0 = fixed PDO, 1 = PPS APDO
pe2ana_trans_voltage  in  10  requested voltage; fixed: 50 mV/LSB, PPS: 20 mV/LSB
pe2ana_trans_current  in  10  requested current; fixed: 10 mA/LSB, PPS: 50 mA/LSB
ana2pe_attached  out  1  sink attached
ana2pe_trans_finish  out  1  one-cycle pulse, transition complete
ana2pe_pps_voltage  out  16  output voltage, 20 mV/LSB
ana2pe_pps_current  out  8  output current, 50 mA/LSB
ana2pe_pps_ptf  out  2  present temperature flag (00 n/a, 01 normal)
ana2pe_pps_omf  out  1  operating-mode flag, 1 = current-limit mode
ana2pe_alert  out  1  one-cycle pulse on OMF rise or PTF change

Behaviour:
- Reset (rst=1 at a clk edge), all outputs 0:
  - attached, trans_finish, pps_voltage, pps_current, ptf, omf and alert all 0.
  - Attach counter cleared; FSM forced to UNATT.
  - Reset applied mid-transition aborts it; no finish pulse follows.
- States: UNATT, IDLE, SETTLE.
- UNATT:
  - Counts ATTACH_DLY cycles after reset release, then goes to IDLE.
  - On entry to IDLE, same edge: attached=1, pps_voltage=250 (5 V), pps_current=60 (3 A), ptf=01.
  - ptf changes 00->01 at this point, so alert pulses once.
  - trans_en is ignored in UNATT.
- attached stays 1 until reset.
- IDLE, trans_en=1 at an edge:
  - Latch pdotype, voltage, current into request registers; go to SETTLE; load counter with SETTLE_DLY-1.
- SETTLE:
  - Counter decrements each cycle.
  - At count 0: trans_finish=1 for exactly one cycle; status outputs update on that same edge; return to IDLE.
  - Request sampled at edge N gives finish high during cycle N+SETTLE_DLY.
- trans_en=1 during SETTLE: re-latch the request and restart the counter (last request wins, single finish).
- trans_en held high after finish re-triggers one cycle later. The policy engine must deassert trans_en on finish.
- Status computation, applied when finish fires:
  - Fixed: pps_voltage = (voltage*5)>>1, zero-extended to 16 bits.
  - Fixed: pps_current = current/5, saturated to 255.
  - Fixed: omf = 0.
  - PPS: pps_voltage = voltage, zero-extended.
  - PPS: pps_current = min(current, PPS_CL_MAX), saturated to 255.
  - PPS: omf = (current > PPS_CL_MAX).
- alert = 1 for one cycle on any edge where omf goes 0->1 or ptf changes value; otherwise 0.
- Simultaneous alert and finish events are both issued on the same cycle.
- Outputs are registered; no combinational input-to-output paths.

Test Plan:
- Reset release, defaults -> attached rises exactly 16 cycles after rst drops; same cycle: pps_voltage=250, pps_current=60, ptf=01, one alert pulse.
- Fixed request before attach (trans_en=1 during UNATT) -> no finish; outputs stay 0 until attach.
- Fixed request, pdotype=0, voltage=180 (9 V), current=300 (3 A) -> finish is a single pulse 64 cycles after sampling; pps_voltage=450, pps_current=60, omf=0, no alert.
- PPS request, pdotype=1, voltage=165 (3.3 V), current=80 -> finish after 64 cycles; pps_voltage=165, pps_current=60, omf=1, alert pulse coincident with finish. A following PPS request with current=40 -> pps_current=40, omf=0, no alert.
- Request restart: second request issued 20 cycles into SETTLE with voltage=100 -> single finish 64 cycles after the second request; pps_voltage reflects 100 (250 fixed).
- Reset mid-SETTLE -> no finish pulse; all outputs 0; attach sequence repeats after ATTACH_DLY cycles.

Source files
------------

// File: rtl/pd_ana_model_if.sv
`default_nettype none
// ============================================================================
// Module      : pd_ana_model_if
// Description : Policy-engine <-> VBUS analog front-end signal bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface pd_ana_model_if;
    logic        pe2ana_trans_en;
    logic        pe2ana_trans_pdotype;
    logic [9:0]  pe2ana_trans_voltage;
    logic [9:0]  pe2ana_trans_current;
    logic        ana2pe_attached;
    logic        ana2pe_trans_finish;
    logic [15:0] ana2pe_pps_voltage;
    logic [7:0]  ana2pe_pps_current;
    logic [1:0]  ana2pe_pps_ptf;
    logic        ana2pe_pps_omf;
    logic        ana2pe_alert;

    modport master (
        output pe2ana_trans_en, pe2ana_trans_pdotype,
        output pe2ana_trans_voltage, pe2ana_trans_current,
        input  ana2pe_attached, ana2pe_trans_finish, ana2pe_pps_voltage,
        input  ana2pe_pps_current, ana2pe_pps_ptf, ana2pe_pps_omf, ana2pe_alert
    );

    modport slave (
        input  pe2ana_trans_en, pe2ana_trans_pdotype,
        input  pe2ana_trans_voltage, pe2ana_trans_current,
        output ana2pe_attached, ana2pe_trans_finish, ana2pe_pps_voltage,
        output ana2pe_pps_current, ana2pe_pps_ptf, ana2pe_pps_omf, ana2pe_alert
    );
endinterface
`default_nettype wire

// File: rtl/pd_ana_model.sv
`default_nettype none
// ============================================================================
// Module      : pd_ana_model
// Description : USB-PD source VBUS front-end model: attach report, timed
//               transition settling and PPS status/alert publication.
// Revision    : 1.0 - initial release
// ============================================================================
module pd_ana_model #(
    parameter int ATTACH_DLY = 16,
    parameter int SETTLE_DLY = 64,
    parameter int PPS_CL_MAX = 60
) (
    input  wire logic     clk,
    input  wire logic     rst,
    pd_ana_model_if.slave bus
);

    localparam int c_att_w = $clog2(ATTACH_DLY + 1);
    localparam int c_stl_w = $clog2(SETTLE_DLY + 1);
    localparam logic [c_att_w-1:0] c_att_last  = c_att_w'(ATTACH_DLY - 1);
    localparam logic [c_stl_w-1:0] c_stl_load  = c_stl_w'(SETTLE_DLY - 1);
    localparam logic [9:0]         c_cl_max    = 10'(PPS_CL_MAX);
    localparam logic [1:0]         c_ptf_norm  = 2'b01;

    typedef enum logic [1:0] {
        S_UNATT  = 2'd0,
        S_IDLE   = 2'd1,
        S_SETTLE = 2'd2
    } state_t;

    state_t             r_state;
    logic [c_att_w-1:0] r_att_cnt;
    logic [c_stl_w-1:0] r_stl_cnt;
    logic               r_req_pps;
    logic [9:0]         r_req_v;
    logic [9:0]         r_req_i;
    logic               r_attached;
    logic               r_finish;
    logic [15:0]        r_pps_v;
    logic [7:0]         r_pps_i;
    logic [1:0]         r_ptf;
    logic               r_omf;
    logic               r_alert;

    // Status values derived from the latched request, committed on finish
    logic [15:0] w_fix_v5;
    logic [15:0] w_fix_v;
    logic [9:0]  w_fix_i;
    logic        w_pps_over;
    logic [9:0]  w_pps_i;
    logic [15:0] w_new_v;
    logic [7:0]  w_new_i;
    logic        w_new_omf;

    always_comb begin
        w_fix_v5   = {6'd0, r_req_v} * 16'd5;
        w_fix_v    = w_fix_v5 >> 1;
        w_fix_i    = r_req_i / 10'd5;
        w_pps_over = (r_req_i > c_cl_max);
        w_pps_i    = w_pps_over ? c_cl_max : r_req_i;
        w_new_v    = 16'd0;
        w_new_i    = 8'd0;
        w_new_omf  = 1'b0;
        if (r_req_pps) begin
            w_new_v   = {6'd0, r_req_v};
            w_new_i   = (w_pps_i > 10'd255) ? 8'hFF : w_pps_i[7:0];
            w_new_omf = w_pps_over;
        end else begin
            w_new_v   = w_fix_v;
            w_new_i   = (w_fix_i > 10'd255) ? 8'hFF : w_fix_i[7:0];
            w_new_omf = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_UNATT;
            r_att_cnt  <= '0;
            r_stl_cnt  <= '0;
            r_req_pps  <= 1'b0;
            r_req_v    <= '0;
            r_req_i    <= '0;
            r_attached <= 1'b0;
            r_finish   <= 1'b0;
            r_pps_v    <= '0;
            r_pps_i    <= '0;
            r_ptf      <= 2'b00;
            r_omf      <= 1'b0;
            r_alert    <= 1'b0;
        end else begin
            r_finish <= 1'b0;
            r_alert  <= 1'b0;
            case (r_state)
                S_UNATT: begin
                    if (r_att_cnt == c_att_last) begin
                        r_state    <= S_IDLE;
                        r_attached <= 1'b1;
                        r_pps_v    <= 16'd250;
                        r_pps_i    <= 8'd60;
                        r_ptf      <= c_ptf_norm;
                        r_alert    <= (r_ptf != c_ptf_norm);
                    end else begin
                        r_att_cnt <= r_att_cnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (bus.pe2ana_trans_en) begin
                        r_req_pps <= bus.pe2ana_trans_pdotype;
                        r_req_v   <= bus.pe2ana_trans_voltage;
                        r_req_i   <= bus.pe2ana_trans_current;
                        r_stl_cnt <= c_stl_load;
                        r_state   <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    // A new request supersedes the one in flight
                    if (bus.pe2ana_trans_en) begin
                        r_req_pps <= bus.pe2ana_trans_pdotype;
                        r_req_v   <= bus.pe2ana_trans_voltage;
                        r_req_i   <= bus.pe2ana_trans_current;
                        r_stl_cnt <= c_stl_load;
                    end else if (r_stl_cnt == '0) begin
                        r_finish <= 1'b1;
                        r_pps_v  <= w_new_v;
                        r_pps_i  <= w_new_i;
                        r_omf    <= w_new_omf;
                        r_alert  <= w_new_omf & ~r_omf;
                        r_state  <= S_IDLE;
                    end else begin
                        r_stl_cnt <= r_stl_cnt - 1'b1;
                    end
                end
                default: r_state <= S_UNATT;
            endcase
        end
    end

    assign bus.ana2pe_attached     = r_attached;
    assign bus.ana2pe_trans_finish = r_finish;
    assign bus.ana2pe_pps_voltage  = r_pps_v;
    assign bus.ana2pe_pps_current  = r_pps_i;
    assign bus.ana2pe_pps_ptf      = r_ptf;
    assign bus.ana2pe_pps_omf      = r_omf;
    assign bus.ana2pe_alert        = r_alert;

endmodule
`default_nettype wire

// File: tb/tb_pd_ana_model.sv
`default_nettype none
// ============================================================================
// Module      : tb_pd_ana_model
// Description : Directed, table-driven bench for pd_ana_model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pd_ana_model;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    pd_ana_model_if bus();

    pd_ana_model #(
        .ATTACH_DLY(16),
        .SETTLE_DLY(64),
        .PPS_CL_MAX(60)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pdo;
        logic [9:0]  v;
        logic [9:0]  c;
        logic [15:0] ev;
        logic [7:0]  ei;
        logic        eomf;
        int          ealert;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic issue_req(input logic pdo, input logic [9:0] v, input logic [9:0] c);
        bus.pe2ana_trans_pdotype = pdo;
        bus.pe2ana_trans_voltage = v;
        bus.pe2ana_trans_current = c;
        bus.pe2ana_trans_en      = 1'b1;
        tick();
        bus.pe2ana_trans_en      = 1'b0;
    endtask

    task automatic wait_fin(input int budget, output int lat, output int nfin, output int nal,
                            output logic al_fin, output logic [15:0] v, output logic [7:0] c,
                            output logic omf);
        lat = -1; nfin = 0; nal = 0; al_fin = 1'b0; v = '0; c = '0; omf = 1'b0;
        for (int k = 1; k <= budget; k++) begin
            tick();
            if (bus.ana2pe_alert) nal++;
            if (bus.ana2pe_trans_finish) begin
                nfin++;
                if (lat < 0) begin
                    lat    = k;
                    al_fin = bus.ana2pe_alert;
                    v      = bus.ana2pe_pps_voltage;
                    c      = bus.ana2pe_pps_current;
                    omf    = bus.ana2pe_pps_omf;
                end
            end
        end
    endtask

    task automatic wait_attach(input int budget, output int k_att, output int nfin, output int nal,
                               output logic [15:0] v, output logic [7:0] c, output logic [1:0] ptf,
                               output logic al_att);
        k_att = -1; nfin = 0; nal = 0; v = '0; c = '0; ptf = '0; al_att = 1'b0;
        for (int k = 1; k <= budget; k++) begin
            tick();
            if (bus.ana2pe_trans_finish) nfin++;
            if (bus.ana2pe_alert) nal++;
            if (bus.ana2pe_attached && k_att < 0) begin
                k_att  = k;
                v      = bus.ana2pe_pps_voltage;
                c      = bus.ana2pe_pps_current;
                ptf    = bus.ana2pe_pps_ptf;
                al_att = bus.ana2pe_alert;
                bus.pe2ana_trans_en = 1'b0;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_attached"}, 32'(bus.ana2pe_attached), 0);
        check({tag, "_finish"},   32'(bus.ana2pe_trans_finish), 0);
        check({tag, "_voltage"},  32'(bus.ana2pe_pps_voltage), 0);
        check({tag, "_current"},  32'(bus.ana2pe_pps_current), 0);
        check({tag, "_ptf"},      32'(bus.ana2pe_pps_ptf), 0);
        check({tag, "_omf"},      32'(bus.ana2pe_pps_omf), 0);
        check({tag, "_alert"},    32'(bus.ana2pe_alert), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          lat, nfin, nal, k_att;
        logic        al_fin, omf, al_att;
        logic [15:0] v;
        logic [7:0]  c;
        logic [1:0]  ptf;

        checks   = 0;
        failures = 0;

        // pdo, v, c, exp voltage, exp current, exp omf, exp alerts
        vecs[0] = '{1'b0, 10'd180,  10'd300,  16'd450,  8'd60,  1'b0, 0};
        vecs[1] = '{1'b1, 10'd165,  10'd80,   16'd165,  8'd60,  1'b1, 1};
        vecs[2] = '{1'b1, 10'd165,  10'd40,   16'd165,  8'd40,  1'b0, 0};
        vecs[3] = '{1'b1, 10'd500,  10'd61,   16'd500,  8'd60,  1'b1, 1};
        vecs[4] = '{1'b1, 10'd500,  10'd60,   16'd500,  8'd60,  1'b0, 0};
        vecs[5] = '{1'b0, 10'd200,  10'd100,  16'd500,  8'd20,  1'b0, 0};
        vecs[6] = '{1'b0, 10'd1023, 10'd1023, 16'd2557, 8'd204, 1'b0, 0};
        vecs[7] = '{1'b1, 10'd1023, 10'd61,   16'd1023, 8'd60,  1'b1, 1};
        vecs[8] = '{1'b1, 10'd1023, 10'd1023, 16'd1023, 8'd60,  1'b1, 0};
        vecs[9] = '{1'b0, 10'd0,    10'd4,    16'd0,    8'd0,   1'b0, 0};

        rst = 1'b1;
        bus.pe2ana_trans_en      = 1'b0;
        bus.pe2ana_trans_pdotype = 1'b0;
        bus.pe2ana_trans_voltage = '0;
        bus.pe2ana_trans_current = '0;
        repeat (3) tick();
        check_all_zero("reset");

        // Release reset with a request already pending; UNATT must ignore it
        rst = 1'b0;
        bus.pe2ana_trans_pdotype = 1'b0;
        bus.pe2ana_trans_voltage = 10'd180;
        bus.pe2ana_trans_current = 10'd300;
        bus.pe2ana_trans_en      = 1'b1;
        wait_attach(30, k_att, nfin, nal, v, c, ptf, al_att);
        check("attach_latency", 32'(k_att), 16);
        check("attach_no_finish", 32'(nfin), 0);
        check("attach_voltage", 32'(v), 250);
        check("attach_current", 32'(c), 60);
        check("attach_ptf", 32'(ptf), 1);
        check("attach_alert_coincident", 32'(al_att), 1);
        check("attach_alert_count", 32'(nal), 1);
        check("attach_still_idle_omf", 32'(bus.ana2pe_pps_omf), 0);

        for (int i = 0; i < 10; i++) begin
            issue_req(vecs[i].pdo, vecs[i].v, vecs[i].c);
            wait_fin(80, lat, nfin, nal, al_fin, v, c, omf);
            check($sformatf("v%0d_latency", i), 32'(lat), 64);
            check($sformatf("v%0d_finish_count", i), 32'(nfin), 1);
            check($sformatf("v%0d_voltage", i), 32'(v), 32'(vecs[i].ev));
            check($sformatf("v%0d_current", i), 32'(c), 32'(vecs[i].ei));
            check($sformatf("v%0d_omf", i), 32'(omf), 32'(vecs[i].eomf));
            check($sformatf("v%0d_alert_count", i), 32'(nal), 32'(vecs[i].ealert));
            check($sformatf("v%0d_alert_at_finish", i), 32'(al_fin), 32'(vecs[i].ealert));
            check($sformatf("v%0d_ptf", i), 32'(bus.ana2pe_pps_ptf), 1);
        end

        // Restart: second request 20 cycles into SETTLE wins, single finish
        issue_req(1'b0, 10'd300, 10'd100);
        wait_fin(20, lat, nfin, nal, al_fin, v, c, omf);
        check("restart_no_early_finish", 32'(nfin), 0);
        issue_req(1'b0, 10'd100, 10'd100);
        wait_fin(90, lat, nfin, nal, al_fin, v, c, omf);
        check("restart_latency", 32'(lat), 64);
        check("restart_finish_count", 32'(nfin), 1);
        check("restart_voltage", 32'(v), 250);
        check("restart_current", 32'(c), 20);
        check("restart_alert_count", 32'(nal), 0);

        // Reset mid-SETTLE aborts the transition, attach sequence repeats
        issue_req(1'b1, 10'd165, 10'd80);
        repeat (30) tick();
        rst = 1'b1;
        tick();
        check_all_zero("midreset");
        rst = 1'b0;
        wait_attach(90, k_att, nfin, nal, v, c, ptf, al_att);
        check("reattach_latency", 32'(k_att), 16);
        check("reattach_no_finish", 32'(nfin), 0);
        check("reattach_voltage", 32'(v), 250);
        check("reattach_current", 32'(c), 60);
        check("reattach_ptf", 32'(ptf), 1);
        check("reattach_alert_count", 32'(nal), 1);
        check("reattach_omf", 32'(bus.ana2pe_pps_omf), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
